pll_mgmt_responder: RTL and testbench
=====================================

Name: pll_mgmt_responder

Overview:
- Avalon-MM management slave: the responder end of the PLL reconfiguration write sequence the memtest top issues on mgmt_*.
- Holds shadow registers for N, M, C counters, fractional K, bandwidth and charge pump.
- A write to the Start register serialises the latched configuration onto a bit-serial reconfig interface, then pulses update.
- Sits between the top-level mgmt initiator and the PLL reconfig port; also serves as the simulation model for that initiator.

Parameters:
- NUM_C, 2, number of C output counters held (1..32).
- CNT_W, 18, width of the N/M/C counter words.

Ports:
- mgmt_clk  in  1  clock; all logic on the rising edge.
- mgmt_reset  in  1  asynchronous, active-high reset.
- mgmt_address  in  6  register address.
- mgmt_write  in  1  write request.
- mgmt_writedata  in  32  write data.
- mgmt_read  in  1  read request.
- mgmt_readdata  out  32  read data; valid in any cycle where mgmt_read=1 and mgmt_waitrequest=0.
- mgmt_waitrequest  out  1  stall; the request is not accepted while this is 1.
- cfg_data  out  1  serial configuration bit, MSB first.
- cfg_shift  out  1  high while cfg_data carries a valid bit.
- cfg_update  out  1  one-cycle pulse after the last bit.
- cfg_busy  out  1  high from the first shift cycle through the update cycle.

Behaviour:
- Reset (async): all shadow registers = 0, mode = 0, state IDLE. mgmt_waitrequest, cfg_data, cfg_shift, cfg_update, cfg_busy and mgmt_readdata = 0. Reset during an apply aborts it immediately; no cfg_update is issued.
- Register map (write acceptance = write=1 and waitrequest=0):
  - 0 MODE: bit0; 0 = waitrequest mode, 1 = polling mode.
  - 1 STATUS: read-only; bit0 = ~cfg_busy.
  - 2 START: any write data triggers an apply.
  - 3 N: [CNT_W-1:0].
  - 4 M: [CNT_W-1:0].
  - 5 C: [22:18] = counter index, [CNT_W-1:0] = value. An index >= NUM_C is ignored.
  - 7 K: [31:0].
  - 8 BW: [3:0].
  - 9 CP: [2:0].
  - Other addresses: writes are ignored, reads return 0.
- Register writes take effect the cycle after acceptance. Unused writedata bits are dropped.
- Reads: mgmt_readdata is a combinational mux, zero-extended. C reads return C[0]. Read and write together: treated as a write; readdata is don't-care.
- States: IDLE -> SHIFT -> UPDATE -> IDLE.
  - START accepted at cycle T (IDLE only): the frame is latched into the shift register at edge T.
  - Frame, MSB first: N, M, C[0]..C[NUM_C-1], K, BW, CP.
  - TOTAL = CNT_W*(2+NUM_C)+39 bits (111 for defaults).
  - SHIFT occupies cycles T+1..T+TOTAL, cfg_shift=1.
  - UPDATE is cycle T+TOTAL+1: cfg_update=1, cfg_shift=0.
  - IDLE from T+TOTAL+2.
  - cfg_busy = 1 for cycles T+1..T+TOTAL+1.
- Waitrequest mode: mgmt_waitrequest = 1 during cycles T+1..T+TOTAL+1, so all requests stall. It is 0 in IDLE.
- Polling mode: mgmt_waitrequest is always 0.
  - Writes during busy update the shadow registers but do not alter the frame in flight.
  - START during busy is ignored (no queueing).
  - STATUS reads 0 while busy.
- A MODE write while busy (polling mode) takes effect immediately for waitrequest generation.
- Counter index and bit counter are sized for TOTAL; there is no wrap within a frame.

Test Plan:
- Reset then read all addresses 0..9 -> readdata 0 everywhere. STATUS reads 1. waitrequest=0. No cfg_shift.
- Default params, MODE=0:
  - Stimulus: N=0x10000, M=0x00808, C[0]=0x20302, K=0xB33332DD, BW=7, CP=1, START.
  - Required: waitrequest high exactly 112 cycles. 111 cfg_shift cycles, and the captured bits equal the concatenated frame with first bit = N[17]=0. Then a single cfg_update pulse.
- MODE=1:
  - Stimulus: START, then write M=0x00404 mid-shift.
  - Required: the frame still carries the old M. Readback of M returns 0x404. STATUS polls 0 then 1 after update. A second START mid-shift produces no second frame.
- C write with writedata = (1<<18)|0x00202 -> C[1]=0x202 appears in the frame. Index 5 with NUM_C=2 -> no register change.
- Assert mgmt_reset at shift bit 50 -> outputs immediately 0. No cfg_update. STATUS=1 and registers 0 after release.
- Simultaneous read+write to addr 4 with data 0x123 -> M=0x123 and the transaction completes in one cycle.

Source files
------------

// File: rtl/pll_mgmt_responder.sv
// Avalon-MM PLL reconfiguration responder: shadow registers plus a
// bit-serial apply engine that shifts the latched frame out MSB first.
module pll_mgmt_responder #(
   parameter int NUM_C = 2,
   parameter int CNT_W = 18
) (
   input  logic        mgmt_clk,
   input  logic        mgmt_reset,
   input  logic [5:0]  mgmt_address,
   input  logic        mgmt_write,
   input  logic [31:0] mgmt_writedata,
   input  logic        mgmt_read,
   output logic [31:0] mgmt_readdata,
   output logic        mgmt_waitrequest,
   output logic        cfg_data,
   output logic        cfg_shift,
   output logic        cfg_update,
   output logic        cfg_busy
);

   localparam int TOTAL = CNT_W * (2 + NUM_C) + 39;
   localparam int CW    = $clog2(TOTAL);

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

   state_e                 state_q, state_d;
   logic                   mode_q, mode_d;
   logic [CNT_W-1:0]       n_q, n_d, m_q, m_d;
   logic [CNT_W-1:0]       c_q [NUM_C];
   logic [CNT_W-1:0]       c_d [NUM_C];
   logic [31:0]            k_q, k_d;
   logic [3:0]             bw_q, bw_d;
   logic [2:0]             cp_q, cp_d;
   logic [TOTAL-1:0]       shreg_q, shreg_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [TOTAL-1:0]       frame;
   logic                   wr_acc;
   logic [4:0]             wr_idx;

   assign mgmt_waitrequest = ~mode_q & (state_q != IDLE);
   assign wr_acc           = mgmt_write & ~mgmt_waitrequest;
   assign wr_idx           = mgmt_writedata[22:18];
   assign cfg_shift        = (state_q == SHIFT);
   assign cfg_update       = (state_q == UPDATE);
   assign cfg_busy         = (state_q != IDLE);
   assign cfg_data         = cfg_shift & shreg_q[TOTAL-1];

   always_comb begin
      frame = '0;
      frame[TOTAL-1 -: CNT_W]         = n_q;
      frame[TOTAL-1-CNT_W -: CNT_W]   = m_q;
      for (int i = 0; i < NUM_C; i++)
         frame[TOTAL-1-CNT_W*(2+i) -: CNT_W] = c_q[i];
      frame[38:7] = k_q;
      frame[6:3]  = bw_q;
      frame[2:0]  = cp_q;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      n_d     = n_q;
      m_d     = m_q;
      c_d     = c_q;
      k_d     = k_q;
      bw_d    = bw_q;
      cp_d    = cp_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (wr_acc) begin
         case (mgmt_address)
            6'd0: mode_d = mgmt_writedata[0];
            6'd3: n_d    = mgmt_writedata[CNT_W-1:0];
            6'd4: m_d    = mgmt_writedata[CNT_W-1:0];
            6'd5: begin
               for (int i = 0; i < NUM_C; i++)
                  if (wr_idx == 5'(i)) c_d[i] = mgmt_writedata[CNT_W-1:0];
            end
            6'd7: k_d    = mgmt_writedata;
            6'd8: bw_d   = mgmt_writedata[3:0];
            6'd9: cp_d   = mgmt_writedata[2:0];
            default: ;
         endcase
      end
      case (state_q)
         IDLE: begin
            // START only launches from IDLE; a busy-time START is dropped
            if (wr_acc && mgmt_address == 6'd2) begin
               state_d = SHIFT;
               shreg_d = frame;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            shreg_d = shreg_q << 1;
            if (cnt_q == CW'(TOTAL - 1)) state_d = UPDATE;
            else cnt_d = cnt_q + 1'b1;
         end
         UPDATE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
      if (mgmt_reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         n_q     <= '0;
         m_q     <= '0;
         c_q     <= '{default: '0};
         k_q     <= '0;
         bw_q    <= '0;
         cp_q    <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         n_q     <= n_d;
         m_q     <= m_d;
         c_q     <= c_d;
         k_q     <= k_d;
         bw_q    <= bw_d;
         cp_q    <= cp_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      mgmt_readdata = '0;
      if (mgmt_read && !mgmt_reset) begin
         case (mgmt_address)
            6'd0: mgmt_readdata[0]         = mode_q;
            6'd1: mgmt_readdata[0]         = (state_q == IDLE);
            6'd3: mgmt_readdata[CNT_W-1:0] = n_q;
            6'd4: mgmt_readdata[CNT_W-1:0] = m_q;
            6'd5: mgmt_readdata[CNT_W-1:0] = c_q[0];
            6'd7: mgmt_readdata            = k_q;
            6'd8: mgmt_readdata[3:0]       = bw_q;
            6'd9: mgmt_readdata[2:0]       = cp_q;
            default: mgmt_readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Directed bench for pll_mgmt_responder: register map table plus
// frame, polling, reset-abort and read+write sequences.
module tb_pll_mgmt_responder;

   localparam int TOTAL = 111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  addr = '0;
   logic        wr = 1'b0;
   logic [31:0] wdata = '0;
   logic        rd = 1'b0;
   logic [31:0] rdata;
   logic        waitreq, cdata, cshift, cupd, cbusy;

   int total = 0;
   int bad = 0;

   pll_mgmt_responder #(.NUM_C(2), .CNT_W(18)) dut (
      .mgmt_clk(clk), .mgmt_reset(rst), .mgmt_address(addr),
      .mgmt_write(wr), .mgmt_writedata(wdata), .mgmt_read(rd),
      .mgmt_readdata(rdata), .mgmt_waitrequest(waitreq),
      .cfg_data(cdata), .cfg_shift(cshift), .cfg_update(cupd),
      .cfg_busy(cbusy)
   );

   always #5 clk = ~clk;

   int sc = 0, uc = 0, wq = 0, sc_at_upd = 0;
   logic [TOTAL-1:0] cap = '0;

   always @(negedge clk) begin
      if (waitreq) wq = wq + 1;
      if (cshift) begin
         cap = {cap[TOTAL-2:0], cdata};
         sc = sc + 1;
      end
      if (cupd) begin
         uc = uc + 1;
         sc_at_upd = sc;
      end
   end

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      #1;
      while (waitreq && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 500) chk({name, " timeout"}, 1, 0);
   endtask

   task automatic wreg(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; wr = 1'b1;
      wait_ready("write");
      @(posedge clk);
      #1 wr = 1'b0;
   endtask

   task automatic rreg(input logic [5:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; rd = 1'b1;
      wait_ready("read");
      d = rdata;
      @(posedge clk);
      #1 rd = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic [5:0]  ra;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[12];
   logic [31:0] d;
   logic [TOTAL-1:0] fexp;
   int base_s, base_u, base_w;

   initial begin
      tbl[0]  = '{"n_trunc",  6'd3,  32'hFFFFFFFF,        6'd3,  32'h3FFFF};
      tbl[1]  = '{"m",        6'd4,  32'h00000808,        6'd4,  32'h808};
      tbl[2]  = '{"c0",       6'd5,  32'h00020302,        6'd5,  32'h20302};
      tbl[3]  = '{"c_idx5",   6'd5,  (32'd5 << 18) | 32'h11111, 6'd5, 32'h20302};
      tbl[4]  = '{"c1_rd_c0", 6'd5,  (32'd1 << 18) | 32'h202,   6'd5, 32'h20302};
      tbl[5]  = '{"k",        6'd7,  32'hB33332DD,        6'd7,  32'hB33332DD};
      tbl[6]  = '{"bw_trunc", 6'd8,  32'hFFFFFFF7,        6'd8,  32'h7};
      tbl[7]  = '{"cp_trunc", 6'd9,  32'h000000F9,        6'd9,  32'h1};
      tbl[8]  = '{"addr6",    6'd6,  32'h0000FFFF,        6'd6,  32'h0};
      tbl[9]  = '{"addr12",   6'd12, 32'h00000001,        6'd12, 32'h0};
      tbl[10] = '{"mode1",    6'd0,  32'h00000003,        6'd0,  32'h1};
      tbl[11] = '{"mode0",    6'd0,  32'h00000000,        6'd0,  32'h0};

      // reset state
      addr = 6'd1; rd = 1'b1;
      #2;
      chk("rst_rdata", rdata, 0);
      chk("rst_waitreq", waitreq, 0);
      chk("rst_busy", {cshift, cupd, cbusy, cdata}, 0);
      rd = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 10; a++) begin
         rreg(6'(a), d);
         chk($sformatf("rst_read%0d", a), d, (a == 1) ? 1 : 0);
      end
      chk("rst_noshift", sc, 0);

      for (int i = 0; i < 12; i++) begin
         wreg(tbl[i].wa, tbl[i].wd);
         rreg(tbl[i].ra, d);
         chk(tbl[i].name, d, tbl[i].exp);
      end

      // waitrequest-mode apply
      do_reset();
      wreg(3, 32'h10000); wreg(4, 32'h00808); wreg(5, 32'h20302);
      wreg(7, 32'hB33332DD); wreg(8, 7); wreg(9, 1);
      base_s = sc; base_u = uc; base_w = wq;
      wreg(2, 0);
      repeat (130) @(negedge clk);
      #1;
      fexp = {18'h10000, 18'h00808, 18'h20302, 18'h0, 32'hB33332DD, 4'h7, 3'h1};
      chk("m0_waitreq_cycles", wq - base_w, 112);
      chk("m0_shift_cycles", sc - base_s, TOTAL);
      chk("m0_frame", cap, fexp);
      chk("m0_first_bit", cap[TOTAL-1], 0);
      chk("m0_update_pulses", uc - base_u, 1);
      chk("m0_update_after_last", sc_at_upd - base_s, TOTAL);

      // polling mode, writes and START during busy
      do_reset();
      wreg(0, 1);
      wreg(3, 32'h12345); wreg(4, 32'h00ABC); wreg(5, 32'h1);
      wreg(5, (32'd1 << 18) | 32'h202);
      wreg(5, (32'd5 << 18) | 32'h3FFFF);
      wreg(7, 32'h12345678); wreg(8, 32'hA); wreg(9, 5);
      base_s = sc; base_u = uc; base_w = wq;
      wreg(2, 0);
      repeat (10) @(negedge clk);
      wreg(4, 32'h00404);
      rreg(4, d);
      chk("m1_m_readback", d, 32'h404);
      rreg(1, d);
      chk("m1_status_busy", d, 0);
      wreg(2, 0);
      repeat (150) @(negedge clk);
      rreg(1, d);
      chk("m1_status_done", d, 1);
      #1;
      fexp = {18'h12345, 18'h00ABC, 18'h00001, 18'h00202, 32'h12345678, 4'hA, 3'h5};
      chk("m1_frame_old_m", cap, fexp);
      chk("m1_one_frame", sc - base_s, TOTAL);
      chk("m1_one_update", uc - base_u, 1);
      chk("m1_no_waitreq", wq - base_w, 0);
      rreg(5, d);
      chk("m1_c0_kept", d, 1);

      // reset mid-shift aborts the apply
      do_reset();
      wreg(3, 32'h3FFFF); wreg(7, 32'hFFFFFFFF);
      base_s = sc; base_u = uc;
      wreg(2, 0);
      begin
         int n = 0;
         while ((sc - base_s) < 50 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
         end
         if (n >= 300) chk("abort_wait timeout", 1, 0);
      end
      rst = 1'b1;
      addr = 6'd1; rd = 1'b1;
      #1;
      chk("abort_outputs", {cshift, cupd, cbusy, cdata, waitreq}, 0);
      chk("abort_rdata", rdata, 0);
      rd = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_update", uc - base_u, 0);
      rreg(1, d);
      chk("abort_status", d, 1);
      rreg(3, d);
      chk("abort_n_cleared", d, 0);
      rreg(7, d);
      chk("abort_k_cleared", d, 0);

      // read and write together is a single-cycle write
      @(negedge clk);
      addr = 6'd4; wdata = 32'h123; wr = 1'b1; rd = 1'b1;
      #1;
      chk("rw_no_stall", waitreq, 0);
      @(posedge clk);
      #1 begin wr = 1'b0; rd = 1'b0; end
      rreg(4, d);
      chk("rw_m", d, 32'h123);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
